// File: rtl/adc_burst_arbiter_if.sv
// Bus bundle between the ADC burst arbiter, its channel FIFOs and the sink.
// The master modport is the arbiter side; slave is the FIFO/sink side.
interface adc_burst_arbiter_if #(
  parameter int WIDTH      = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]            fifo_empty_in;
  logic [WIDTH*DATA_WIDTH-1:0] fifo_data_in;
  logic [WIDTH-1:0]            fifo_read;
  logic                        sink_ready;
  logic                        sink_near_full;
  logic                        write_out;
  logic [DATA_WIDTH-1:0]       data_out;
  logic [CW-1:0]               ch_out;
  logic [WIDTH-1:0]            grant;

  modport master (
    input  fifo_empty_in, fifo_data_in, sink_ready, sink_near_full,
    output fifo_read, write_out, data_out, ch_out, grant
  );

  modport slave (
    output fifo_empty_in, fifo_data_in, sink_ready, sink_near_full,
    input  fifo_read, write_out, data_out, ch_out, grant
  );
endinterface

// File: rtl/adc_burst_arbiter.sv
// Round-robin burst arbiter: grants one FWFT channel FIFO at a time and
// streams up to MAX_BURST words from it into a single sink, one cycle after
// each pop. A burst ends on the count limit, an empty FIFO or sink throttle.
module adc_burst_arbiter #(
  parameter int WIDTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                bus_clk,
  input  logic                bus_rst,
  adc_burst_arbiter_if.master bus
);
  localparam int               CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [7:0]       MAX_B    = 8'(MAX_BURST);
  localparam logic [CW-1:0]    LAST_RST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE_HOT0 = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [CW-1:0]         cur_r;
  logic [CW-1:0]         last_r;
  logic [CW-1:0]         pick_s;
  logic                  found_s;
  logic                  pop_s;
  logic                  exit_s;
  logic [7:0]            bcnt_r;
  logic [WIDTH-1:0]      grant_r;
  logic [WIDTH-1:0]      fifo_read_s;
  logic                  write_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [CW-1:0]         ch_r;

  // Channel reached `offset` steps after `base`, wrapping at WIDTH.
  function automatic logic [CW-1:0] rr_index(input logic [CW-1:0] base, input int offset);
    return CW'((int'(base) + offset) % WIDTH);
  endfunction

  // Round-robin search: first non-empty channel after the last one served.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    for (int k = 1; k <= WIDTH; k++) begin
      pick_s  = (!found_s && !bus.fifo_empty_in[rr_index(last_r, k)]) ? rr_index(last_r, k) : pick_s;
      found_s = found_s | !bus.fifo_empty_in[rr_index(last_r, k)];
    end
  end

  // Pop strobe and burst termination for the granted channel.
  always_comb begin
    pop_s       = (state_r == BURST) && !bus.fifo_empty_in[cur_r] && bus.sink_ready && (bcnt_r < MAX_B);
    exit_s      = (pop_s && ((bcnt_r + 8'd1) == MAX_B)) || bus.fifo_empty_in[cur_r] || bus.sink_near_full;
    fifo_read_s = pop_s ? (ONE_HOT0 << cur_r) : '0;
  end

  // Next-state decode: start a burst when a channel is ready and the sink is not throttling.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (found_s && !bus.sink_near_full) begin
          state_nxt_s = BURST;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BURST: begin
        if (exit_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BURST;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant, burst counter and round-robin pointer.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      cur_r   <= '0;
      last_r  <= LAST_RST;
      bcnt_r  <= 8'd0;
      grant_r <= '0;
    end else if (state_r == IDLE) begin
      if (state_nxt_s == BURST) begin
        cur_r   <= pick_s;
        grant_r <= ONE_HOT0 << pick_s;
        bcnt_r  <= 8'd0;
      end else begin
        grant_r <= '0;
      end
    end else begin
      if (pop_s) begin
        bcnt_r <= bcnt_r + 8'd1;
      end
      if (exit_s) begin
        last_r  <= cur_r;
        grant_r <= '0;
      end
    end
  end

  // Registered sink outputs: a popped word appears on the next edge; otherwise data/channel hold.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      write_r <= 1'b0;
      data_r  <= '0;
      ch_r    <= '0;
    end else begin
      write_r <= pop_s;
      if (pop_s) begin
        data_r <= bus.fifo_data_in[DATA_WIDTH*cur_r +: DATA_WIDTH];
        ch_r   <= cur_r;
      end
    end
  end

  assign bus.fifo_read = fifo_read_s;
  assign bus.write_out = write_r;
  assign bus.data_out  = data_r;
  assign bus.ch_out    = ch_r;
  assign bus.grant     = grant_r;
endmodule

// File: tb/tb_adc_burst_arbiter.sv
// Scoreboard bench for adc_burst_arbiter: FIFO models feed the DUT, every
// loaded word is queued as an expected output per channel, and expected
// bursts (channel, length) are queued per test. A negedge monitor pops and
// compares whenever the DUT writes a word or drops a grant.
module tb_adc_burst_arbiter;
  localparam int W  = 4;
  localparam int DW = 32;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  adc_burst_arbiter_if #(.WIDTH(W), .DATA_WIDTH(DW)) bus ();

  adc_burst_arbiter #(.WIDTH(W), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .bus_clk (clk),
    .bus_rst (rst),
    .bus     (bus)
  );

  logic [DW-1:0] fifo_q [W][$];
  logic [DW-1:0] exp_q  [W][$];
  int            bch_q[$];
  int            blen_q[$];
  int            gap_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            pops [W];
  logic [W-1:0]  rd;

  int            cyc = 0;
  int            wcnt = 0;
  int            fall_cyc = 0;
  logic          have_fall = 1'b0;
  logic [W-1:0]  prev_grant = '0;
  logic          prev_pop = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int enc(input logic [W-1:0] g);
    for (int i = 0; i < W; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic refresh();
    for (int i = 0; i < W; i++) begin
      bus.fifo_empty_in[i]        = (fifo_q[i].size() == 0);
      bus.fifo_data_in[DW*i +: DW] = (fifo_q[i].size() == 0) ? '0 : fifo_q[i][0];
    end
  endtask

  // One clock: capture pops before the edge, update the FWFT models after it.
  task automatic step();
    @(negedge clk);
    rd = bus.fifo_read;
    @(posedge clk);
    #1;
    for (int i = 0; i < W; i++) begin
      if (rd[i]) begin
        if (fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
        pops[i]++;
      end
    end
    refresh();
  endtask

  task automatic load(input int ch, input int n, input int tag);
    logic [DW-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = (32'(ch) << 28) | (32'(tag) << 16) | 32'(k);
      fifo_q[ch].push_back(w);
      exp_q[ch].push_back(w);
    end
    refresh();
  endtask

  task automatic burst(input int ch, input int len);
    bch_q.push_back(ch);
    blen_q.push_back(len);
  endtask

  function automatic bit idle_now();
    bit r;
    r = (bus.grant == '0) && (bus.write_out == 1'b0) && (bch_q.size() == 0);
    for (int i = 0; i < W; i++) r = r && (fifo_q[i].size() == 0) && (exp_q[i].size() == 0);
    return r;
  endfunction

  task automatic wait_idle(input int limit, input string name);
    int k;
    k = 0;
    while (!idle_now() && k < limit) begin
      step();
      k++;
    end
    check(name, idle_now(), 1);
  endtask

  task automatic wait_grant(input logic [W-1:0] g, input int limit, input string name);
    int k;
    k = 0;
    while (bus.grant !== g && k < limit) begin
      step();
      k++;
    end
    check(name, bus.grant, g);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    #1;
    check("rst_grant", bus.grant, 0);
    check("rst_fifo_read", bus.fifo_read, 0);
    check("rst_write_out", bus.write_out, 0);
    check("rst_data_out", bus.data_out, 0);
    check("rst_ch_out", bus.ch_out, 0);
    for (int i = 0; i < W; i++) begin
      fifo_q[i].delete();
      exp_q[i].delete();
    end
    refresh();
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  task automatic clear_gaps();
    gap_q.delete();
    have_fall = 1'b0;
  endtask

  task automatic check_gaps(input int n, input string name);
    check(name, gap_q.size(), n);
    foreach (gap_q[i]) check({name, "_len"}, gap_q[i], 1);
  endtask

  // Monitor: invariants every cycle, word scoreboard on writes, burst scoreboard on grant drop.
  always @(negedge clk) begin
    cyc++;
    check("grant_onehot0", $onehot0(bus.grant), 1);
    check("read_in_grant", bus.fifo_read & ~bus.grant, 0);
    check("read_nonempty", bus.fifo_read & bus.fifo_empty_in, 0);
    if (!rst) check("write_latency", bus.write_out, prev_pop);
    if (bus.write_out === 1'b1) begin
      wcnt++;
      check("word_pending", exp_q[bus.ch_out].size() > 0, 1);
      if (exp_q[bus.ch_out].size() > 0) check("word_data", bus.data_out, exp_q[bus.ch_out].pop_front());
    end
    if (prev_grant != '0 && bus.grant == '0) begin
      check("burst_pending", bch_q.size() > 0, 1);
      if (bch_q.size() > 0) begin
        check("burst_ch", enc(prev_grant), bch_q.pop_front());
        check("burst_len", wcnt, blen_q.pop_front());
      end
      wcnt      = 0;
      fall_cyc  = cyc;
      have_fall = 1'b1;
    end
    if (prev_grant == '0 && bus.grant != '0 && have_fall) gap_q.push_back(cyc - fall_cyc);
    prev_grant = bus.grant;
    prev_pop   = (bus.fifo_read != '0) && !rst;
  end

  logic sr_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int k;
    int left;
    rst = 1'b0;
    bus.sink_ready     = 1'b1;
    bus.sink_near_full = 1'b0;
    for (int i = 0; i < W; i++) pops[i] = 0;
    refresh();
    #1;

    // Reset state, then idle with empty FIFOs.
    do_reset(3);
    step();
    check("t0_idle_grant", bus.grant, 0);
    check("t0_idle_write", bus.write_out, 0);

    // 40 words on ch0: bursts 16, 16, 8 with one idle cycle between.
    clear_gaps();
    load(0, 40, 1);
    burst(0, 16); burst(0, 16); burst(0, 8);
    wait_idle(300, "t1_done");
    check_gaps(2, "t1_gap");

    // All channels 20 words from reset: 0,1,2,3 x16 then 0,1,2,3 x4.
    do_reset(2);
    clear_gaps();
    for (int c = 0; c < W; c++) load(c, 20, 2);
    for (int c = 0; c < W; c++) burst(c, 16);
    for (int c = 0; c < W; c++) burst(c, 4);
    wait_idle(500, "t2_done");
    check_gaps(7, "t2_gap");

    // Ch2 burst with sink_ready 1,0,0,1: two pops, grant held.
    bus.sink_ready = 1'b0;
    load(2, 10, 3);
    burst(2, 10);
    wait_grant(4'b0100, 20, "t3_grant");
    pops[2] = 0;
    for (int i = 0; i < 4; i++) begin
      bus.sink_ready = sr_seq[i];
      step();
      check("t3_grant_hold", bus.grant, 4'b0100);
    end
    bus.sink_ready = 1'b0;
    check("t3_pops", pops[2], 2);
    check("t3_bcnt", dut.bcnt_r, 2);
    bus.sink_ready = 1'b1;
    wait_idle(100, "t3_done");

    // Throttle raised together with ch1's fifth pop; ch2 follows after release.
    load(1, 12, 4);
    load(2, 3, 4);
    burst(1, 5); burst(2, 3); burst(1, 7);
    wait_grant(4'b0010, 20, "t4_grant_ch1");
    pops[1] = 0;
    k = 0;
    while (pops[1] < 4 && k < 50) begin
      step();
      k++;
    end
    check("t4_pre_pops", pops[1], 4);
    bus.sink_near_full = 1'b1;
    step();
    check("t4_pops", pops[1], 5);
    check("t4_exit_grant", bus.grant, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_hold_grant", bus.grant, 0);
      check("t4_hold_read", bus.fifo_read, 0);
    end
    bus.sink_near_full = 1'b0;
    wait_grant(4'b0100, 5, "t4_grant_ch2");
    wait_idle(100, "t4_done");

    // Single word on ch3, then the search restarts at ch0.
    load(3, 1, 5);
    burst(3, 1);
    wait_grant(4'b1000, 20, "t5_grant_ch3");
    wait_idle(50, "t5_done");
    check("t5_last", dut.last_r, 3);
    load(2, 2, 6);
    load(0, 2, 6);
    burst(0, 2); burst(2, 2);
    wait_idle(100, "t5_next_search");

    // Reset in the middle of a ch1 burst; afterwards ch0 is searched first.
    load(1, 10, 7);
    burst(1, 2);
    wait_grant(4'b0010, 20, "t6_grant_ch1");
    pops[1] = 0;
    k = 0;
    while (pops[1] < 3 && k < 50) begin
      step();
      k++;
    end
    check("t6_pops", pops[1], 3);
    do_reset(2);
    load(2, 2, 8);
    load(0, 2, 8);
    burst(0, 2); burst(2, 2);
    wait_idle(100, "t6_after_reset");

    left = 0;
    for (int i = 0; i < W; i++) left += exp_q[i].size();
    check("words_outstanding", left, 0);
    check("bursts_outstanding", bch_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/adc_burst_arbiter.md
ADC_BURST_ARBITER -- requirements
Module: adc_burst_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: number of requesting ADC channel FIFOs (2..8).
REQ-002 Parameter DATA_WIDTH, default 32: word width per channel.
REQ-003 Parameter MAX_BURST, default 16: maximum words popped per grant (1..255).
REQ-004 BUS_CLK  in  1  sole clock; all state on rising edge.
REQ-005 BUS_RST  in  1  asynchronous, active-high reset.
REQ-006 FIFO_EMPTY_IN  in  WIDTH  per-channel empty flag of first-word-fall-through FIFOs.
REQ-007 FIFO_DATA_IN  in  WIDTH*DATA_WIDTH  channel i word at bits [DATA_WIDTH*i +: DATA_WIDTH].
REQ-008 FIFO_READ  out  WIDTH  per-channel pop strobe.
REQ-009 SINK_READY  in  1  sink accepts a word in the cycle after this is high.
REQ-010 SINK_NEAR_FULL  in  1  sink throttle request.
REQ-011 WRITE_OUT  out  1  registered word-valid to sink.
REQ-012 DATA_OUT  out  DATA_WIDTH  registered word to sink.
REQ-013 CH_OUT  out  clog2(WIDTH)  registered source channel of DATA_OUT.
REQ-014 GRANT  out  WIDTH  one-hot current grant; all-zero when idle.

Function
REQ-015 The FSM SHALL have two states: IDLE and BURST.
REQ-016 IDLE: if SINK_NEAR_FULL=0 and any FIFO_EMPTY_IN bit is 0, the block SHALL select the first non-empty channel searching LAST+1, LAST+2, ... modulo WIDTH, load GRANT, clear BCNT and enter BURST on the next edge.
REQ-017 IDLE with no non-empty channel, or with SINK_NEAR_FULL=1, SHALL remain IDLE with GRANT=0.
REQ-018 BURST: FIFO_READ[g] SHALL be combinationally asserted when GRANT[g]=1, FIFO_EMPTY_IN[g]=0, SINK_READY=1 and BCNT<MAX_BURST; all other FIFO_READ bits SHALL be 0.
REQ-019 At every pop, BCNT SHALL increment, and on the next edge WRITE_OUT=1, DATA_OUT=word of g sampled at the pop, CH_OUT=g (latency 1 cycle).
REQ-020 Cycles without a pop SHALL give WRITE_OUT=0; DATA_OUT and CH_OUT SHALL hold their previous value.
REQ-021 BURST SHALL exit to IDLE on the next edge when any of the following holds: the pop makes BCNT=MAX_BURST; FIFO_EMPTY_IN[g]=1; or SINK_NEAR_FULL=1. On exit, LAST SHALL be set to g and GRANT cleared.
REQ-022 SINK_READY=0 in BURST SHALL stall without a pop and SHALL NOT end the burst.
REQ-023 If SINK_NEAR_FULL and the final burst pop coincide, the pop SHALL complete; the word SHALL be written, and then IDLE is entered.
REQ-024 A channel that empties after one pop SHALL yield; re-arbitration costs exactly one IDLE cycle (BURST->IDLE->BURST).
REQ-025 GRANT SHALL be one-hot or zero; FIFO_READ SHALL be a subset of GRANT.
REQ-026 Each popped word SHALL appear exactly once on the output, with no duplication or loss.
REQ-027 Round-robin fairness: a continuously non-empty channel SHALL be granted within WIDTH-1 bursts of any other channel.

Reset
REQ-028 While BUS_RST=1, the block SHALL hold: state IDLE, GRANT=0, FIFO_READ=0, WRITE_OUT=0, DATA_OUT=0, CH_OUT=0, BCNT=0, LAST=WIDTH-1 (channel 0 is searched first).
REQ-029 Reset asserted mid-burst SHALL immediately drop FIFO_READ and WRITE_OUT; a word popped in the reset cycle's preceding edge is discarded.
REQ-030 Operation SHALL resume on the first edge after BUS_RST deasserts.

Verification
REQ-031 Reset, then ch0 holds 40 words, SINK_READY=1, MAX_BURST=16 -> bursts of 16, 16, 8, each separated by one idle cycle; WRITE_OUT one cycle after each FIFO_READ[0]; CH_OUT=0.
REQ-032 All 4 channels hold 20 words -> grant order 0,1,2,3,0,1,2,3; first pass 16 words each, second pass 4 words each; 80 words total, in order per channel.
REQ-033 Ch2 granted, SINK_READY toggles 1,0,0,1 -> exactly 2 pops, BCNT=2, GRANT stays 4'b0100.
REQ-034 SINK_NEAR_FULL=1 asserted after 5 pops of ch1 -> IDLE next edge; no grant while high; after release, ch2 is granted if non-empty, otherwise ch1.
REQ-035 Only ch3 non-empty with 1 word -> single pop, WRITE_OUT=1 with CH_OUT=3, then IDLE; LAST=3, so the next search starts at ch0.
REQ-036 BUS_RST pulsed during a ch1 burst -> all outputs 0 within the reset cycle; after release, ch0 is searched first.
